// File: rtl/mdu_seq_if.sv
// Execute-stage <-> multiply/divide sequencer bundle: decoded instruction in,
// status, read data and architectural HI/LO out.
interface mdu_seq_if #(parameter int unsigned WIDTH = 32);
  logic             issue;
  logic [3:0]       ALUop;
  logic [5:0]       FuncCode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             stall;
  logic             illegal;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output issue, ALUop, FuncCode, a, b,
                  input  busy, done, stall, rd_data, illegal, hi, lo);
  modport slave  (input  issue, ALUop, FuncCode, a, b,
                  output busy, done, stall, rd_data, illegal, hi, lo);
endinterface

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, one iteration per cycle.
// Define MDU_DIV_EN to build the restoring divider; otherwise DIV/DIVU report illegal.
module mdu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  mdu_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, sh_q, opnd_q, hi_q, lo_q;
  logic             neg_q, busy_q, done_q;
`ifdef MDU_DIV_EN
  logic             div_q, rneg_q, dz_q;
`endif

  logic             dec, f_mfhi, f_mflo, f_mthi, f_mtlo, f_mul, f_div, div_ok;
  logic             legal, accept, start, sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign dec    = bus.issue && (bus.ALUop == 4'b1111);
  assign f_mfhi = (bus.FuncCode == F_MFHI);
  assign f_mflo = (bus.FuncCode == F_MFLO);
  assign f_mthi = (bus.FuncCode == F_MTHI);
  assign f_mtlo = (bus.FuncCode == F_MTLO);
  assign f_mul  = (bus.FuncCode == F_MULT) || (bus.FuncCode == F_MULTU);
  assign f_div  = (bus.FuncCode == F_DIV)  || (bus.FuncCode == F_DIVU);

`ifdef MDU_DIV_EN
  assign div_ok      = f_div;
  assign bus.illegal = 1'b0;
`else
  assign div_ok      = 1'b0;
  assign bus.illegal = dec && f_div;
`endif

  assign legal  = dec && (f_mfhi || f_mflo || f_mthi || f_mtlo || f_mul || div_ok);
  assign accept = legal && (state_q != S_RUN);
  assign start  = accept && (f_mul || div_ok);

  // Signed variants have funct bit 0 clear; the datapath only sees magnitudes.
  assign sgn   = ~bus.FuncCode[0];
  assign a_neg = sgn & bus.a[WIDTH-1];
  assign b_neg = sgn & bus.b[WIDTH-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  assign bus.stall   = legal && (state_q == S_RUN);
  assign bus.rd_data = (accept && f_mfhi) ? hi_q :
                       (accept && f_mflo) ? lo_q : '0;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_d, sh_d, hi_d, lo_d;
  logic [2*WIDTH-1:0] prod;
`ifdef MDU_DIV_EN
  logic [WIDTH:0]     shifted, diff;
`endif

  // acc_q/sh_q hold {upper, lower} product halves, or {remainder, dividend/quotient}.
  always_comb begin
    sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    acc_d = sum[WIDTH:1];
    sh_d  = {sum[0], sh_q[WIDTH-1:1]};
    prod  = {acc_d, sh_d};
    if (neg_q) prod = -prod;
    {hi_d, lo_d} = prod;
`ifdef MDU_DIV_EN
    shifted = {acc_q, sh_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (div_q) begin
      acc_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], ~diff[WIDTH]};
      lo_d  = dz_q ? '1 : (neg_q ? -sh_d : sh_d);
      hi_d  = rneg_q ? -acc_d : acc_d;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(WIDTH - 1);
            acc_q   <= '0;
            neg_q   <= a_neg ^ b_neg;
            sh_q    <= div_ok ? a_mag : b_mag;
            opnd_q  <= div_ok ? b_mag : a_mag;
`ifdef MDU_DIV_EN
            div_q   <= f_div;
            rneg_q  <= a_neg;
            dz_q    <= (bus.b == '0);
`endif
          end else if (accept && f_mthi) begin
            hi_q <= bus.a;
          end else if (accept && f_mtlo) begin
            lo_q <= bus.a;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: cycle-level model of HI/LO/busy/done compared every cycle,
// plus directed vectors with literal expectations on 32-bit and 8-bit instances.
module tb_mdu_seq;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_seq_if #(.WIDTH(32)) bus ();
  mdu_seq_if #(.WIDTH(8))  bus8 ();

  mdu_seq #(.WIDTH(32)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  mdu_seq #(.WIDTH(8))  u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int n_err = 0;
  int n_chk = 0;
  int k, nst;
  bit seen;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result {hi, lo} for a w-bit operation, straight from the arithmetic rules.
  function automatic logic [127:0] mdu_model(input int w, input logic [5:0] f,
                                            input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0] mask, av, bv, p, hv, lv;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    av = ai & mask;
    bv = bi & mask;
    sa = av[w-1] ? longint'(av | ~mask) : longint'(av);
    sb = bv[w-1] ? longint'(bv | ~mask) : longint'(bv);
    hv = '0;
    lv = '0;
    case (f)
      MULT:  begin p = sa * sb; hv = (p >> w) & mask; lv = p & mask; end
      MULTU: begin p = av * bv; hv = (p >> w) & mask; lv = p & mask; end
      DIV:   if (bv == 0) begin lv = mask; hv = av; end
             else begin q = sa / sb; r = sa % sb; lv = q & mask; hv = r & mask; end
      DIVU:  if (bv == 0) begin lv = mask; hv = av; end
             else begin lv = (av / bv) & mask; hv = (av % bv) & mask; end
      default: ;
    endcase
    return {hv, lv};
  endfunction

  // Reference state for the 32-bit instance.
  logic [63:0]  m_hi = '0, m_lo = '0;
  logic [127:0] m_pend = '0;
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic         m_dec, m_isdiv, m_legal;

  assign m_dec   = bus.issue && (bus.ALUop == 4'hF);
  assign m_isdiv = (bus.FuncCode == DIV) || (bus.FuncCode == DIVU);
  assign m_legal = m_dec && ((bus.FuncCode inside {MFHI, MTHI, MFLO, MTLO, MULT, MULTU})
                             || (DIV_EN && m_isdiv));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_hi <= m_pend[127:64];
        m_lo <= m_pend[63:0];
      end
      if (m_left != 0) m_left <= m_left - 1;
      if (m_legal && m_left == 0) begin
        case (bus.FuncCode)
          MTHI: m_hi <= {32'd0, bus.a};
          MTLO: m_lo <= {32'd0, bus.a};
          MULT, MULTU, DIV, DIVU: begin
            m_pend <= mdu_model(32, bus.FuncCode, {32'd0, bus.a}, {32'd0, bus.b});
            m_left <= 32;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",    bus.busy,    m_left != 0);
    chk("done",    bus.done,    m_done);
    chk("stall",   bus.stall,   m_legal && m_left != 0);
    chk("illegal", bus.illegal, m_dec && m_isdiv && !DIV_EN);
    chk("rd_data", bus.rd_data,
        (m_legal && m_left == 0 && bus.FuncCode == MFHI) ? m_hi :
        (m_legal && m_left == 0 && bus.FuncCode == MFLO) ? m_lo : 64'd0);
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic iss, input logic [5:0] fc, input logic [31:0] av,
                     input logic [31:0] bv, input logic [3:0] op = 4'hF);
    bus.issue = iss; bus.ALUop = op; bus.FuncCode = fc; bus.a = av; bus.b = bv;
  endtask

  task automatic idle;
    put(1'b0, 6'h00, 32'd0, 32'd0, 4'h0);
  endtask

  // Returns the cycle index (issue edge N -> cycle N+k) in which done is seen.
  task automatic wait_done(output int kk);
    kk = 1;
    while (!bus.done && kk < 64) begin
      tick;
      kk++;
    end
  endtask

  task automatic run_op(input logic [5:0] fc, input logic [31:0] av, input logic [31:0] bv,
                        output int kk);
    put(1'b1, fc, av, bv);
    tick;
    idle;
    wait_done(kk);
  endtask

  initial begin
    idle;
    bus8.issue = 1'b0; bus8.ALUop = 4'h0; bus8.FuncCode = 6'h00; bus8.a = '0; bus8.b = '0;

    chk("pin_mult32",  mdu_model(32, MULT,  64'hFFFFFFFE, 64'd3), {64'hFFFFFFFF, 64'hFFFFFFFA});
    chk("pin_multu8",  mdu_model(8,  MULTU, 64'hFF, 64'hFF),      {64'hFE, 64'h01});
    chk("pin_div32",   mdu_model(32, DIV,   64'hFFFFFFF9, 64'd2), {64'hFFFFFFFF, 64'hFFFFFFFD});
    chk("pin_divmin",  mdu_model(32, DIV,   64'h80000000, 64'hFFFFFFFF), {64'h0, 64'h80000000});

    tick; tick;
    put(1'b1, MFHI, 32'd0, 32'd0);
    #1;
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_hi",      bus.hi, 0);
    chk("rst_lo",      bus.lo, 0);
    chk("rst_busy",    bus.busy, 0);
    tick;
    rst_n = 1'b1;
    idle;
    tick;

    run_op(MULT, 32'hFFFFFFFE, 32'd3, k);
    chk("mult_latency", k, 33);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFFA);
    put(1'b1, MFHI, 32'd0, 32'd0);
    #1;
    chk("mfhi_in_done", bus.rd_data, 32'hFFFFFFFF);
    chk("mfhi_no_stall", bus.stall, 0);
    tick;

    run_op(MULTU, 32'hFFFFFFFE, 32'd3, k);
    chk("multu_hi", bus.hi, 32'h00000002);
    chk("multu_lo", bus.lo, 32'hFFFFFFFA);
    idle;
    tick;

    put(1'b1, MULT, 32'd5, 32'd7);
    tick;
    put(1'b1, MFLO, 32'd0, 32'd0);
    nst = 0;
    #1;
    while (bus.stall && nst < 40) begin
      nst++;
      tick;
      #1;
    end
    chk("mflo_stall_cycles", nst, 32);
    chk("mflo_done_cycle", bus.done, 1);
    chk("mflo_new_lo", bus.rd_data, 32'd35);

    put(1'b1, MULT, 32'h00010000, 32'h00010000);
    tick;
    chk("b2b_busy", bus.busy, 1);
    idle;
    wait_done(k);
    chk("b2b_latency", k, 33);
    chk("b2b_hi", bus.hi, 32'h00000001);
    chk("b2b_lo", bus.lo, 32'h00000000);
    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, k);
    chk("multu_max_hi", bus.hi, 32'hFFFFFFFE);
    chk("multu_max_lo", bus.lo, 32'h00000001);

    put(1'b1, MULT, 32'd9, 32'd9);
    tick;
    put(1'b1, MTHI, 32'h0000DEAD, 32'd0);
    nst = 0;
    #1;
    while (bus.stall && nst < 40) begin
      nst++;
      tick;
      #1;
    end
    chk("mthi_stall_cycles", nst, 32);
    tick;
    idle;
    chk("mthi_after_run", bus.hi, 32'h0000DEAD);
    chk("mult_lo_kept", bus.lo, 32'd81);

    put(1'b1, MTHI, 32'h0000FFFF, 32'd0, 4'h0);
    tick;
    put(1'b1, 6'h20, 32'h0000FFFF, 32'd0);
    tick;
    idle;
    chk("ignored_hi", bus.hi, 32'h0000DEAD);
    chk("ignored_busy", bus.busy, 0);

`ifdef MDU_DIV_EN
    put(1'b1, DIV, 32'hFFFFFFF9, 32'd2);
    #1;
    chk("div_legal", bus.illegal, 0);
    tick;
    idle;
    wait_done(k);
    chk("div_latency", k, 33);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_hi", bus.hi, 32'hFFFFFFFF);
    run_op(DIVU, 32'd7, 32'd0, k);
    chk("divu0_lo", bus.lo, 32'hFFFFFFFF);
    chk("divu0_hi", bus.hi, 32'd7);
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, k);
    chk("divmin_lo", bus.lo, 32'h80000000);
    chk("divmin_hi", bus.hi, 32'd0);
    run_op(DIVU, 32'd100, 32'd7, k);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);
    run_op(DIV, 32'hFFFFFFF7, 32'd0, k);
    chk("div0s_lo", bus.lo, 32'hFFFFFFFF);
    chk("div0s_hi", bus.hi, 32'hFFFFFFF7);
`else
    put(1'b1, DIV, 32'hFFFFFFF9, 32'd2);
    #1;
    chk("div_illegal", bus.illegal, 1);
    chk("div_no_stall", bus.stall, 0);
    tick;
    put(1'b1, DIVU, 32'd7, 32'd0);
    #1;
    chk("divu_illegal", bus.illegal, 1);
    tick;
    idle;
    chk("div_no_busy", bus.busy, 0);
    tick; tick;
    chk("div_hi_kept", bus.hi, 32'h0000DEAD);
    chk("div_lo_kept", bus.lo, 32'd81);
`endif
    idle;
    tick;

    put(1'b1, MULT, 32'd3, 32'd3);
    tick;
    idle;
    repeat (9) tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    tick;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick;
      if (bus.done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    put(1'b1, MTHI, 32'h00001234, 32'd0);
    tick;
    idle;
    chk("mthi_after_abort", bus.hi, 32'h00001234);

    bus8.issue = 1'b1; bus8.ALUop = 4'hF; bus8.FuncCode = MULTU; bus8.a = 8'hFF; bus8.b = 8'hFF;
    tick;
    bus8.issue = 1'b0;
    k = 1;
    while (!bus8.done && k < 32) begin
      tick;
      k++;
    end
    chk("w8_latency", k, 9);
    chk("w8_busy_in_done", bus8.busy, 0);
    chk("w8_hi", bus8.hi, 8'hFE);
    chk("w8_lo", bus8.lo, 8'h01);
    tick;
    bus8.issue = 1'b1; bus8.FuncCode = MULT; bus8.a = 8'h80; bus8.b = 8'h80;
    tick;
    bus8.issue = 1'b0;
    repeat (9) tick;
    chk("w8_mult_hi", bus8.hi, 8'h40);
    chk("w8_mult_lo", bus8.lo, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
